// File: rtl/lsu_mem_initiator_pkg.sv
// lsu_pkg: access codes, FSM encoding and size/alignment helpers for the load/store initiator
package lsu_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {IDLE, LD0, LD1, STB, ST, RESP} state_t;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      return (f3 == F3_W) ? 3'd4 : (f3 == F3_H || f3 == F3_HU) ? 3'd2 : 3'd1;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      return ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'd0);
   endfunction

   // unsigned widths only exist for loads
   function automatic logic f3_legal(input logic [2:0] f3, input logic store);
      return f3 == F3_B || f3 == F3_H || f3 == F3_W || (!store && (f3 == F3_BU || f3 == F3_HU));
   endfunction
endpackage

// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: execute-stage request/response and data RAM signals of the load/store initiator
interface lsu_mem_initiator_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_load;
   logic        mem_store;
   logic [2:0]  mem_access;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_fault,
             mem_load, mem_store, mem_access, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_fault,
             mem_load, mem_store, mem_access, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_mem_initiator_load_merge.sv
// lsu_load_merge: extracts a misaligned load from two consecutive RAM words and extends it
module lsu_load_merge
   import lsu_pkg::*;
(
   input  logic [63:0] words,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [31:0] sh;

   assign sh = 32'(words >> {off, 3'b000});

   always_comb
      data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
             funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
             funct3 == F3_BU ? {24'b0, sh[7:0]} :
             funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: load/store initiator from execute stage to byte-enabled data RAM;
// misaligned loads become one or two word reads, misaligned stores become byte writes.
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter bit MISALIGN_EN = 1'b1
) (
   input logic clk,
   input logic rst_n,
   lsu_mem_initiator_if.master bus
);
   state_t      state, nxt;
   logic [2:0]  f3_q;
   logic [31:0] a_q, wd_q, w0_q, res_q;
   logic        flt_q;
   logic [1:0]  cnt;
   logic        hs, mis_in, flt_in, mis, two;
   logic [2:0]  sz;
   logic [31:0] wbase, merged;
   logic [7:0]  wbyte;

   assign bus.req_ready  = state == IDLE && rst_n;
   assign hs             = bus.req_valid && bus.req_ready;
   assign mis_in         = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
   assign flt_in         = !f3_legal(bus.req_funct3, bus.req_store) || (mis_in && !MISALIGN_EN);
   assign mis            = is_misaligned(f3_q, a_q[1:0]);
   assign sz             = size_of(f3_q);
   assign two            = {1'b0, a_q[1:0]} + sz > 3'd4;
   assign wbase          = {a_q[31:2], 2'b00};
   assign wbyte          = 8'(wd_q >> {cnt, 3'b000});
   assign bus.resp_rdata = res_q;
   assign bus.resp_fault = flt_q;

   // in LD1 the low word was captured last cycle, the high word is on the bus now
   lsu_load_merge u_merge (
      .words  ({bus.mem_rdata, state == LD1 ? w0_q : bus.mem_rdata}),
      .off    (a_q[1:0]),
      .funct3 (f3_q),
      .data   (merged)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;

   always_comb begin
      nxt            = state;
      bus.resp_valid = 1'b0;
      bus.mem_load   = 1'b0;
      bus.mem_store  = 1'b0;
      bus.mem_access = 3'b000;
      bus.mem_addr   = 32'b0;
      bus.mem_wdata  = 32'b0;
      case (state)
         IDLE: if (hs) nxt = flt_in ? RESP : bus.req_store ? (mis_in ? STB : ST) : LD0;
         LD0: begin
            bus.mem_load   = 1'b1;
            bus.mem_access = mis ? F3_W : f3_q;
            bus.mem_addr   = mis ? wbase : a_q;
            nxt            = mis && two ? LD1 : RESP;
         end
         LD1: begin
            bus.mem_load   = 1'b1;
            bus.mem_access = F3_W;
            bus.mem_addr   = wbase + 32'd4;
            nxt            = RESP;
         end
         ST: begin
            bus.mem_store  = 1'b1;
            bus.mem_access = f3_q;
            bus.mem_addr   = a_q;
            bus.mem_wdata  = wd_q;
            nxt            = RESP;
         end
         STB: begin
            bus.mem_store  = 1'b1;
            bus.mem_access = F3_B;
            bus.mem_addr   = a_q + {30'b0, cnt};
            bus.mem_wdata  = {24'b0, wbyte};
            nxt            = {1'b0, cnt} == sz - 3'd1 ? RESP : STB;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            nxt            = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         f3_q  <= 3'b0;
         a_q   <= 32'b0;
         wd_q  <= 32'b0;
         w0_q  <= 32'b0;
         res_q <= 32'b0;
         flt_q <= 1'b0;
         cnt   <= 2'b0;
      end else begin
         if (hs) begin
            f3_q  <= bus.req_funct3;
            a_q   <= bus.req_addr;
            wd_q  <= bus.req_wdata;
            res_q <= 32'b0;
            flt_q <= flt_in;
            cnt   <= 2'b0;
         end
         if (state == LD0) begin
            w0_q  <= bus.mem_rdata;
            res_q <= mis ? merged : bus.mem_rdata;
         end
         if (state == LD1) res_q <= merged;
         if (state == STB) cnt <= cnt + 2'd1;
      end
endmodule
